reg_file_mp: RTL and testbench

REG_FILE_MP -- requirements
Module: reg_file_mp

---
 rtl/reg_file_pkg.sv | 9 +
 rtl/rf_scoreboard.sv | 50 +++++
 rtl/reg_file_mp.sv | 118 +++++++++++
 tb/tb_reg_file_mp.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// reg_file_pkg: default geometry shared by the multi-port register file and
// its busy scoreboard.
package reg_file_pkg;

  localparam int unsigned DEFAULT_DATA_W = 32;
  localparam int unsigned DEFAULT_ADDR_W = 5;
  localparam int unsigned DEPTH          = 2 ** DEFAULT_ADDR_W;

endpackage : reg_file_pkg

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: one busy bit per register, marking a pending producer.
//   clk_i/rst_i            clock, asynchronous active-low reset
//   set_en_i/set_addr_i    reserve request (sets busy)
//   clr0_*/clr1_*          write ports (clear busy of the written register)
//   ra_addr_i/rb_addr_i    read taps
//   ra_busy_o/rb_busy_o    registered busy bit of the tapped register
module rf_scoreboard
  import reg_file_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEFAULT_ADDR_W,
  parameter bit          R0_ZERO = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              set_en_i,
  input  logic [ADDR_W-1:0] set_addr_i,
  input  logic              clr0_en_i,
  input  logic [ADDR_W-1:0] clr0_addr_i,
  input  logic              clr1_en_i,
  input  logic [ADDR_W-1:0] clr1_addr_i,
  input  logic [ADDR_W-1:0] ra_addr_i,
  input  logic [ADDR_W-1:0] rb_addr_i,
  output logic              ra_busy_o,
  output logic              rb_busy_o
);

  localparam int unsigned N = 2 ** ADDR_W;

  logic [N-1:0] busy_q;
  logic [N-1:0] busy_d;

  // Clears applied first so a same-cycle reserve overrides them: the
  // register has a new producer even though this write lands.
  always_comb begin
    busy_d = busy_q;
    if (clr0_en_i) busy_d[clr0_addr_i] = 1'b0;
    if (clr1_en_i) busy_d[clr1_addr_i] = 1'b0;
    if (set_en_i)  busy_d[set_addr_i]  = 1'b1;
    if (R0_ZERO)   busy_d[0]           = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign ra_busy_o = busy_q[ra_addr_i];
  assign rb_busy_o = busy_q[rb_addr_i];

endmodule : rf_scoreboard

// File: rtl/reg_file_mp.sv
// reg_file_mp: 2-read / 2-write register file with destination reservation.
//   clk_i, rst_i                  clock, asynchronous active-low reset
//   RSaddr_i/RSdata_o/RSbusy_o    read port A
//   RTaddr_i/RTdata_o/RTbusy_o    read port B
//   W0en_i/W0addr_i/W0data_i      write port 0
//   W1en_i/W1addr_i/W1data_i      write port 1 (wins over W0 on same address)
//   RSVen_i/RSVaddr_i             reserve-destination request
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_W  = DEFAULT_DATA_W,
  parameter int unsigned ADDR_W  = DEFAULT_ADDR_W,
  parameter bit          R0_ZERO = 1'b1,
  parameter bit          BYPASS  = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] RSaddr_i,
  input  logic [ADDR_W-1:0] RTaddr_i,
  output logic [DATA_W-1:0] RSdata_o,
  output logic [DATA_W-1:0] RTdata_o,
  output logic              RSbusy_o,
  output logic              RTbusy_o,
  input  logic              W0en_i,
  input  logic [ADDR_W-1:0] W0addr_i,
  input  logic [DATA_W-1:0] W0data_i,
  input  logic              W1en_i,
  input  logic [ADDR_W-1:0] W1addr_i,
  input  logic [DATA_W-1:0] W1data_i,
  input  logic              RSVen_i,
  input  logic [ADDR_W-1:0] RSVaddr_i
);

  localparam int unsigned N = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [N];
  logic [DATA_W-1:0] regs_d [N];

  logic w0_we;
  logic w1_we;
  logic rs_hit;
  logic rt_hit;
  logic rs_busy_reg;
  logic rt_busy_reg;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;

  // Writes to a hardwired zero register are dropped; this also keeps
  // bypass off for address 0.
  assign w0_we = W0en_i && !(R0_ZERO && (W0addr_i == '0));
  assign w1_we = W1en_i && !(R0_ZERO && (W1addr_i == '0));

  always_comb begin
    regs_d = regs_q;
    if (w0_we) regs_d[W0addr_i] = W0data_i;
    if (w1_we) regs_d[W1addr_i] = W1data_i;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) regs_q <= '{default: '0};
    else        regs_q <= regs_d;
  end

  always_comb begin
    rs_data = (R0_ZERO && (RSaddr_i == '0)) ? '0 : regs_q[RSaddr_i];
    rs_hit  = 1'b0;
    if (BYPASS && rst_i) begin
      if (w1_we && (W1addr_i == RSaddr_i)) begin
        rs_data = W1data_i;
        rs_hit  = 1'b1;
      end else if (w0_we && (W0addr_i == RSaddr_i)) begin
        rs_data = W0data_i;
        rs_hit  = 1'b1;
      end
    end
  end

  always_comb begin
    rt_data = (R0_ZERO && (RTaddr_i == '0)) ? '0 : regs_q[RTaddr_i];
    rt_hit  = 1'b0;
    if (BYPASS && rst_i) begin
      if (w1_we && (W1addr_i == RTaddr_i)) begin
        rt_data = W1data_i;
        rt_hit  = 1'b1;
      end else if (w0_we && (W0addr_i == RTaddr_i)) begin
        rt_data = W0data_i;
        rt_hit  = 1'b1;
      end
    end
  end

  rf_scoreboard #(
    .ADDR_W  (ADDR_W),
    .R0_ZERO (R0_ZERO)
  ) u_scoreboard (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .set_en_i    (RSVen_i),
    .set_addr_i  (RSVaddr_i),
    .clr0_en_i   (W0en_i),
    .clr0_addr_i (W0addr_i),
    .clr1_en_i   (W1en_i),
    .clr1_addr_i (W1addr_i),
    .ra_addr_i   (RSaddr_i),
    .rb_addr_i   (RTaddr_i),
    .ra_busy_o   (rs_busy_reg),
    .rb_busy_o   (rt_busy_reg)
  );

  assign RSdata_o = rs_data;
  assign RTdata_o = rt_data;

  // A forwarded write satisfies the pending producer, unless this same
  // cycle reserves the register again.
  assign RSbusy_o = rs_busy_reg && !(rs_hit && !(RSVen_i && (RSVaddr_i == RSaddr_i)));
  assign RTbusy_o = rt_busy_reg && !(rt_hit && !(RSVen_i && (RSVaddr_i == RTaddr_i)));

endmodule : reg_file_mp

// File: tb/tb_reg_file_mp.sv
module tb_reg_file_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [4:0]  rs_addr, rt_addr, w0_addr, w1_addr, rsv_addr;
  logic        w0_en, w1_en, rsv_en;
  logic [31:0] w0_data, w1_data;

  logic [31:0] rs_d_a, rt_d_a, rs_d_b, rt_d_b;
  logic        rs_b_a, rt_b_a, rs_b_b, rt_b_b;

  reg_file_mp #(.DATA_W(32), .ADDR_W(5), .R0_ZERO(1'b1), .BYPASS(1'b1)) u_dut (
    .clk_i(clk), .rst_i(rst_n),
    .RSaddr_i(rs_addr), .RTaddr_i(rt_addr),
    .RSdata_o(rs_d_a), .RTdata_o(rt_d_a), .RSbusy_o(rs_b_a), .RTbusy_o(rt_b_a),
    .W0en_i(w0_en), .W0addr_i(w0_addr), .W0data_i(w0_data),
    .W1en_i(w1_en), .W1addr_i(w1_addr), .W1data_i(w1_data),
    .RSVen_i(rsv_en), .RSVaddr_i(rsv_addr)
  );

  reg_file_mp #(.DATA_W(32), .ADDR_W(5), .R0_ZERO(1'b1), .BYPASS(1'b0)) u_dut_nb (
    .clk_i(clk), .rst_i(rst_n),
    .RSaddr_i(rs_addr), .RTaddr_i(rt_addr),
    .RSdata_o(rs_d_b), .RTdata_o(rt_d_b), .RSbusy_o(rs_b_b), .RTbusy_o(rt_b_b),
    .W0en_i(w0_en), .W0addr_i(w0_addr), .W0data_i(w0_data),
    .W1en_i(w1_en), .W1addr_i(w1_addr), .W1data_i(w1_data),
    .RSVen_i(rsv_en), .RSVaddr_i(rsv_addr)
  );

  typedef struct {
    string       name;
    logic [31:0] rs_d, rt_d, rs_d_nb, rt_d_nb;
    logic        rs_b, rt_b, rs_b_nb, rt_b_nb;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference state: architectural register contents and pending flags.
  logic [31:0] mem  [32];
  bit          busy [32];

  function automatic void model_clear();
    for (int i = 0; i < 32; i++) begin
      mem[i]  = 32'h0;
      busy[i] = 1'b0;
    end
  endfunction

  // What a read of address a should show this cycle.
  function automatic void predict(input logic [4:0] a, input bit byp,
                                  output logic [31:0] d, output logic b);
    d = mem[a];
    b = busy[a];
    if (!rst_n || a == 5'd0) begin
      d = 32'h0;
      b = 1'b0;
    end else if (byp && ((w1_en && w1_addr == a) || (w0_en && w0_addr == a))) begin
      d = (w1_en && w1_addr == a) ? w1_data : w0_data;
      if (!(rsv_en && rsv_addr == a)) b = 1'b0;
    end
  endfunction

  task automatic chk(input string nm, input string field,
                     input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s %s got=%h want=%h", nm, field, got, want);
    end
  endtask

  // Monitor: outputs are settled mid-cycle, one expectation per cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk(e.name, "rs_data",    rs_d_a, e.rs_d);
        chk(e.name, "rt_data",    rt_d_a, e.rt_d);
        chk(e.name, "rs_busy",    {31'b0, rs_b_a}, {31'b0, e.rs_b});
        chk(e.name, "rt_busy",    {31'b0, rt_b_a}, {31'b0, e.rt_b});
        chk(e.name, "nb_rs_data", rs_d_b, e.rs_d_nb);
        chk(e.name, "nb_rt_data", rt_d_b, e.rt_d_nb);
        chk(e.name, "nb_rs_busy", {31'b0, rs_b_b}, {31'b0, e.rs_b_nb});
        chk(e.name, "nb_rt_busy", {31'b0, rt_b_b}, {31'b0, e.rt_b_nb});
      end
    end
  end

  // One clock of stimulus: drive, record expectation, then advance the model.
  task automatic cyc(input string nm,
                     input bit e0, input logic [4:0] a0, input logic [31:0] d0,
                     input bit e1, input logic [4:0] a1, input logic [31:0] d1,
                     input bit er, input logic [4:0] ar,
                     input logic [4:0] rsa, input logic [4:0] rta);
    exp_t e;
    w0_en = e0; w0_addr = a0; w0_data = d0;
    w1_en = e1; w1_addr = a1; w1_data = d1;
    rsv_en = er; rsv_addr = ar;
    rs_addr = rsa; rt_addr = rta;
    if (!rst_n) model_clear();
    e.name = nm;
    predict(rsa, 1'b1, e.rs_d, e.rs_b);
    predict(rta, 1'b1, e.rt_d, e.rt_b);
    predict(rsa, 1'b0, e.rs_d_nb, e.rs_b_nb);
    predict(rta, 1'b0, e.rt_d_nb, e.rt_b_nb);
    exp_q.push_back(e);
    @(posedge clk);
    if (rst_n) begin
      if (e0 && a0 != 5'd0) mem[a0] = d0;
      if (e1 && a1 != 5'd0) mem[a1] = d1;
      if (e0) busy[a0] = 1'b0;
      if (e1) busy[a1] = 1'b0;
      if (er) busy[ar] = 1'b1;
      busy[0] = 1'b0;
    end
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    w0_en = 0; w0_addr = 0; w0_data = 0;
    w1_en = 0; w1_addr = 0; w1_data = 0;
    rsv_en = 0; rsv_addr = 0; rs_addr = 0; rt_addr = 0;
    model_clear();
    @(posedge clk);
    #1;

    // Reset holds everything at zero and ignores writes/reserves.
    cyc("rst_hold0", 1, 5, 32'hBEEF, 0, 0, 0, 1, 5, 5, 5);
    cyc("rst_hold1", 0, 0, 0, 1, 5, 32'hBEEF, 0, 0, 5, 0);
    rst_n = 1'b1;
    cyc("post_rst", 0, 0, 0, 0, 0, 0, 0, 0, 5, 5);

    // Write r5 with reservation, reset mid-run, r5 must read back zero.
    cyc("w_r5",      1, 5, 32'h1234, 0, 0, 0, 1, 5, 5, 0);
    cyc("rd_r5",     0, 0, 0, 0, 0, 0, 0, 0, 5, 5);
    rst_n = 1'b0;
    cyc("rst_mid",   0, 0, 0, 1, 5, 32'h9999, 0, 0, 5, 5);
    rst_n = 1'b1;
    cyc("rd_r5_rst", 0, 0, 0, 0, 0, 0, 0, 0, 5, 5);

    // Dual write to one address: W1 wins.
    cyc("dual_w_r7", 1, 7, 32'hAAAA, 1, 7, 32'h5555, 0, 0, 7, 7);
    cyc("rd_r7",     0, 0, 0, 0, 0, 0, 0, 0, 7, 6);

    // Bypass versus stored value.
    cyc("w_r3_old",  1, 3, 32'h1111, 0, 0, 0, 0, 0, 2, 4);
    cyc("byp_r3",    1, 3, 32'hDEAD, 0, 0, 0, 0, 0, 3, 7);
    cyc("rd_r3",     0, 0, 0, 0, 0, 0, 0, 0, 3, 3);

    // Register 0 stays zero and never busy.
    cyc("w_r0",      0, 0, 0, 1, 0, 32'hFFFF, 1, 0, 0, 0);
    cyc("rd_r0",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Scoreboard: reserve, write+reserve keeps busy, plain write clears.
    cyc("rsv_r9",    0, 0, 0, 0, 0, 0, 1, 9, 0, 9);
    cyc("w_rsv_r9",  1, 9, 32'h77, 0, 0, 0, 1, 9, 9, 9);
    cyc("w1_r9",     0, 0, 0, 1, 9, 32'h88, 0, 0, 0, 9);
    cyc("rd_r9",     0, 0, 0, 0, 0, 0, 0, 0, 9, 9);

    // Random traffic over a small address window so collisions are common.
    for (int n = 0; n < 300; n++) begin
      rst_n = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      cyc("rand",
          $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
          $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
          $urandom_range(0, 3) == 0, 5'($urandom_range(0, 7)),
          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    rst_n = 1'b1;

    for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(negedge clk);
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_reg_file_mp
